// File: rtl/flexbex_efpga_arbiter.sv
// flexbex_efpga_arbiter: round-robin sharing of one eFPGA custom-instruction unit between cores
module flexbex_efpga_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CORES-1:0]    req_i,
    input  logic [2*NUM_CORES-1:0]  operator_i,
    input  logic [32*NUM_CORES-1:0] operand_a_i,
    input  logic [32*NUM_CORES-1:0] operand_b_i,
    output logic [NUM_CORES-1:0]    done_o,
    output logic                    error_o,
    output logic [31:0]             result_o,
    output logic                    efpga_strobe_o,
    output logic [1:0]              efpga_operator_o,
    output logic [31:0]             efpga_op_a_o,
    output logic [31:0]             efpga_op_b_o,
    input  logic                    efpga_done_i,
    input  logic [31:0]             efpga_result_a_i,
    input  logic [31:0]             efpga_result_b_i,
    input  logic [31:0]             efpga_result_c_i,
    output logic                    busy_o
);
    localparam int IW = $clog2(NUM_CORES);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;

    logic [1:0]             state;
    logic [IW-1:0]          rr_ptr, grant, pick;
    logic [15:0]            timer;
    logic                   abandon;
    logic [NUM_CORES-1:0]   rot;
    logic [2*NUM_CORES-1:0] req2;
    logic [31:0]            res_sel;

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner.
    assign req2 = {req_i, req_i};
    assign rot  = NUM_CORES'(req2 >> rr_ptr);

    always_comb begin
        pick = rr_ptr;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (rot[i]) pick = IW'((int'(rr_ptr) + i) % NUM_CORES);
    end

    assign res_sel = efpga_operator_o == 2'b00 ? efpga_result_a_i :
                     efpga_operator_o == 2'b01 ? efpga_result_b_i :
                     efpga_operator_o == 2'b10 ? efpga_result_c_i : 32'h0;

    assign efpga_strobe_o = state == ISSUE;
    assign busy_o         = state != IDLE;
    // A core that dropped its request mid-transaction gets no completion pulse.
    assign done_o         = (state == RESP && !abandon) ? NUM_CORES'(1) << grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            grant            <= '0;
            timer            <= '0;
            abandon          <= 1'b0;
            efpga_operator_o <= '0;
            efpga_op_a_o     <= '0;
            efpga_op_b_o     <= '0;
            result_o         <= '0;
            error_o          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_i) begin
                    grant            <= pick;
                    efpga_operator_o <= 2'(operator_i >> (2 * pick));
                    efpga_op_a_o     <= 32'(operand_a_i >> (32 * pick));
                    efpga_op_b_o     <= 32'(operand_b_i >> (32 * pick));
                    abandon          <= 1'b0;
                    state            <= ISSUE;
                end
                ISSUE: begin
                    timer   <= '0;
                    abandon <= abandon | !req_i[grant];
                    state   <= WAIT;
                end
                WAIT: begin
                    timer   <= timer + 1'b1;
                    abandon <= abandon | !req_i[grant];
                    if (efpga_done_i) begin
                        result_o <= res_sel;
                        error_o  <= 1'b0;
                        state    <= RESP;
                    end else if (timer == 16'(TIMEOUT - 1)) begin
                        result_o <= '0;
                        error_o  <= 1'b1;
                        state    <= RESP;
                    end
                end
                default: begin
                    rr_ptr <= (grant == IW'(NUM_CORES - 1)) ? '0 : grant + 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_flexbex_efpga_arbiter.sv
// tb_flexbex_efpga_arbiter: random request/fabric traffic checked against a timestamp-based transaction model
module tb_flexbex_efpga_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_i;
    logic [2*N-1:0]  operator_i;
    logic [32*N-1:0] operand_a_i, operand_b_i;
    logic [N-1:0]    done_o;
    logic            error_o;
    logic [31:0]     result_o;
    logic            efpga_strobe_o;
    logic [1:0]      efpga_operator_o;
    logic [31:0]     efpga_op_a_o, efpga_op_b_o;
    logic            efpga_done_i;
    logic [31:0]     ra, rb, rc;
    logic            busy_o;

    always #5 clk = ~clk;

    flexbex_efpga_arbiter #(.NUM_CORES(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .operator_i(operator_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .done_o(done_o), .error_o(error_o), .result_o(result_o),
        .efpga_strobe_o(efpga_strobe_o), .efpga_operator_o(efpga_operator_o),
        .efpga_op_a_o(efpga_op_a_o), .efpga_op_b_o(efpga_op_b_o),
        .efpga_done_i(efpga_done_i), .efpga_result_a_i(ra),
        .efpga_result_b_i(rb), .efpga_result_c_i(rc), .busy_o(busy_o)
    );

    int errors = 0, checks = 0, cyc = 0;
    // Transaction model: t_grant is the launch cycle, t_end the completion cycle (-1 while open).
    bit          active = 0, m_aband = 0, m_err = 0;
    int          t_grant = 0, t_end = -1, m_ptr = 0, m_grant = 0;
    logic [1:0]  m_op = '0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        for (int d = 0; d < N; d++)
            if (r[(ptr + d) % N]) return (ptr + d) % N;
        return -1;
    endfunction

    function automatic logic [31:0] fabric_word(input logic [1:0] op);
        case (op)
            2'b00:   return ra;
            2'b01:   return rb;
            2'b10:   return rc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic run_phase(input int ncyc, input int preq, input int pdone, input int pdrop,
                             input bit tie, input int prst, input bit init);
        logic [N-1:0] exp_done;
        int k;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            exp_done = (active && cyc == t_end && !m_aband) ? N'(1) << m_grant : '0;
            chk("busy", 32'(busy_o), 32'(active && cyc >= t_grant));
            chk("strobe", 32'(efpga_strobe_o), 32'(active && cyc == t_grant));
            chk("done", 32'(done_o), 32'(exp_done));
            chk("result", result_o, m_res);
            chk("error", 32'(error_o), 32'(m_err));
            chk("op", 32'(efpga_operator_o), 32'(m_op));
            chk("op_a", efpga_op_a_o, m_a);
            chk("op_b", efpga_op_b_o, m_b);
            rst = init || (active && $urandom_range(99) < prst);
            for (int c = 0; c < N; c++) begin
                if (exp_done[c]) req_i[c] = 1'b0;
                else if (!req_i[c]) req_i[c] = $urandom_range(99) < preq;
                else if ($urandom_range(99) < pdrop) req_i[c] = 1'b0;
            end
            if (init) req_i = 4'b0101;
            efpga_done_i = tie ? (active && t_end < 0 && cyc > t_grant && cyc - t_grant - 1 == TO - 1)
                               : ($urandom_range(99) < pdone);
            operator_i  = 8'($urandom);
            operand_a_i = {$urandom, $urandom, $urandom, $urandom};
            operand_b_i = {$urandom, $urandom, $urandom, $urandom};
            ra = $urandom; rb = $urandom; rc = $urandom;
            if (rst) begin
                active = 0; m_ptr = 0; m_grant = 0; m_aband = 0;
                m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_err = 0;
            end else if (!active) begin
                k = rr_pick(req_i, m_ptr);
                if (k >= 0) begin
                    active = 1; t_grant = cyc + 1; t_end = -1; m_grant = k; m_aband = 0;
                    m_op = 2'(operator_i >> (2 * k));
                    m_a  = 32'(operand_a_i >> (32 * k));
                    m_b  = 32'(operand_b_i >> (32 * k));
                end
            end else if (cyc == t_end) begin
                m_ptr  = (m_grant + 1) % N;
                active = 0;
            end else begin
                if (!req_i[m_grant]) m_aband = 1;
                if (cyc > t_grant) begin
                    if (efpga_done_i) begin
                        m_res = fabric_word(m_op); m_err = 0; t_end = cyc + 1;
                    end else if (cyc - t_grant - 1 == TO - 1) begin
                        m_res = 32'h0; m_err = 1; t_end = cyc + 1;
                    end
                end
            end
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; req_i = 4'b0101; efpga_done_i = 1'b0;
        operator_i = '0; operand_a_i = '0; operand_b_i = '0;
        ra = '0; rb = '0; rc = '0;
        run_phase(3,   0,   50,  0, 0, 0, 1);
        run_phase(300, 30,  30,  2, 0, 0, 0);
        run_phase(200, 100, 100, 0, 0, 0, 0);
        run_phase(200, 40,  0,   0, 0, 0, 0);
        run_phase(200, 60,  0,   0, 1, 0, 0);
        run_phase(300, 50,  15,  10, 0, 0, 0);
        run_phase(300, 50,  20,  2, 0, 4, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
